tri_lat_seq: RTL and testbench

- Sequencing controller for a bank of scannable inverting master/slave latches; the bank's data, act (d1clk) and hold (d2clk, active-low) inputs are driven by this block.
- Drives the bank's d, d1clk, d2clk and sreset from a single registered control point.
- Shares the bank's one write port among NREQ requesters using round-robin.
- Sequences power-on init, global hold and a fixed-length scan window.

---
 rtl/tri_lat_seq_pkg.sv | 21 ++
 rtl/tri_lat_seq_rr_arb.sv | 40 ++++
 rtl/tri_lat_seq.sv | 200 ++++++++++++++++++++
 tb/tb_tri_lat_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_lat_seq_pkg.sv
// tri_lat_seq_pkg
// Shared types and helpers for the latch-bank sequencer and its arbiter.
//   state_t  : sequencer state encoding
//   CNT_W    : width of the sequencer's init/scan counter
//   rr_next  : round-robin pointer advance (winner + 1, wrapping at nreq)
package tri_lat_seq_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_SCAN = 2'b11
    } state_t;

    localparam int CNT_W = 8;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nreq);
        return (idx + 32'd1 >= nreq) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/tri_lat_seq_rr_arb.sv
// tri_rr_arb
// Combinational round-robin arbiter: picks the first requester at or after
// i_rr_ptr, wrapping modulo NREQ. Shared with the multi-bank sequencer.
// Ports:
//   i_req     [NREQ]  request vector
//   i_rr_ptr  [PW]    starting search position
//   i_en              gates all outputs to zero when low
//   o_gnt     [NREQ]  one-hot winner
//   o_win_idx [PW]    winner index
//   o_any             a winner exists
module tri_rr_arb #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_rr_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_win_idx,
    output logic            o_any
);

    logic [PW-1:0] w_k;

    always_comb begin
        o_gnt     = '0;
        o_win_idx = '0;
        o_any     = 1'b0;
        w_k       = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_k = PW'((32'(i_rr_ptr) + 32'(off)) % NREQ);
            if (i_en && !o_any && i_req[w_k]) begin
                o_gnt[w_k] = 1'b1;
                o_win_idx  = w_k;
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tri_lat_seq.sv
// tri_lat_seq
// Sequencer for a bank of scannable inverting master/slave latches. Drives the
// bank's d / d1clk / d2clk / sreset from registers, runs power-on init, global
// hold and an optional fixed-length scan window, and shares the bank write port
// among NREQ requesters round-robin.
// Optional feature macro: TRI_LAT_SEQ_SCAN_EN (scan window; off by default).
// Ports:
//   clk, rst (async, active-high)
//   thold_req          global hold request
//   req [NREQ]         level write requests, req_data [NREQ*WIDTH]
//   scan_req           scan window request
//   gnt [NREQ]         registered one-hot grant
//   lat_d, lat_d1clk, lat_d2clk, lat_sreset   latch bank controls
//   scan_active, scan_done                     scan window status
//
// state | meaning
// INIT  | sreset asserted, bank frozen for RST_CYCLES after reset release
// RUN   | arbitrate and write one requester per cycle
// HOLD  | bank frozen (d2clk=0) while thold_req is high
// SCAN  | SCAN_LEN-cycle shift window, no writes
module tri_lat_seq
    import tri_lat_seq_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 8,
    parameter int RST_CYCLES = 4,
    parameter int SCAN_LEN   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  thold_req,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic                  scan_req,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      lat_d,
    output logic                  lat_d1clk,
    output logic                  lat_d2clk,
    output logic                  lat_sreset,
    output logic                  scan_active,
    output logic                  scan_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef TRI_LAT_SEQ_SCAN_EN
    localparam int CW = CNT_W;
`else
    localparam int CW = ($clog2(RST_CYCLES + 1) < CNT_W) ? $clog2(RST_CYCLES + 1) : CNT_W;
`endif

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_rr_ptr;
    logic [NREQ-1:0]   r_gnt;
    logic [WIDTH-1:0]  r_lat_d;
    logic              r_d1clk;
    logic              r_d2clk;
    logic              r_sreset;

    logic [NREQ-1:0]   w_arb_gnt;
    logic [PW-1:0]     w_win_idx;
    logic              w_any;
    logic              w_scan_go;
    logic              w_arb_en;
    logic [WIDTH-1:0]  w_data [NREQ];

`ifdef TRI_LAT_SEQ_SCAN_EN
    logic              r_scan_pend;
    logic              r_scan_active;
    logic              r_scan_done;

    // A scan requested while held is remembered and started once back in RUN.
    assign w_scan_go   = scan_req | r_scan_pend;
    assign scan_active = r_scan_active;
    assign scan_done   = r_scan_done;
`else
    logic              w_unused_scan;

    assign w_unused_scan = scan_req ^ (SCAN_LEN == 0);
    assign w_scan_go     = 1'b0;
    assign scan_active   = 1'b0;
    assign scan_done     = 1'b0;
`endif

    for (genvar g = 0; g < NREQ; g++) begin : g_data
        assign w_data[g] = req_data[g*WIDTH +: WIDTH];
    end

    // Only arbitrate when a grant can actually be issued this cycle.
    assign w_arb_en = (r_state == ST_RUN) && !thold_req && !w_scan_go;

    tri_rr_arb #(
        .NREQ(NREQ),
        .PW  (PW)
    ) u_arb (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .i_en     (w_arb_en),
        .o_gnt    (w_arb_gnt),
        .o_win_idx(w_win_idx),
        .o_any    (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_cnt      <= '0;
            r_rr_ptr   <= '0;
            r_gnt      <= '0;
            r_lat_d    <= '0;
            r_d1clk    <= 1'b0;
            r_d2clk    <= 1'b0;
            r_sreset   <= 1'b1;
`ifdef TRI_LAT_SEQ_SCAN_EN
            r_scan_pend   <= 1'b0;
            r_scan_active <= 1'b0;
            r_scan_done   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_cnt == CW'(RST_CYCLES - 1)) begin
                        r_state  <= ST_RUN;
                        r_cnt    <= '0;
                        r_sreset <= 1'b0;
                        r_d2clk  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (thold_req) begin
                        r_state <= ST_HOLD;
                        r_gnt   <= '0;
                        r_d1clk <= 1'b0;
                        r_d2clk <= 1'b0;
`ifdef TRI_LAT_SEQ_SCAN_EN
                        r_scan_pend <= r_scan_pend | scan_req;
`endif
                    end
`ifdef TRI_LAT_SEQ_SCAN_EN
                    else if (w_scan_go) begin
                        r_state       <= ST_SCAN;
                        r_cnt         <= '0;
                        r_gnt         <= '0;
                        r_d1clk       <= 1'b0;
                        r_scan_pend   <= 1'b0;
                        r_scan_active <= 1'b1;
                        r_scan_done   <= (SCAN_LEN == 1);
                    end
`endif
                    else if (w_any) begin
                        r_gnt    <= w_arb_gnt;
                        r_lat_d  <= w_data[w_win_idx];
                        r_d1clk  <= 1'b1;
                        r_rr_ptr <= PW'(rr_next(32'(w_win_idx), NREQ));
                    end else begin
                        r_gnt   <= '0;
                        r_d1clk <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    r_gnt   <= '0;
                    r_d1clk <= 1'b0;
`ifdef TRI_LAT_SEQ_SCAN_EN
                    r_scan_pend <= r_scan_pend | scan_req;
`endif
                    if (!thold_req) begin
                        r_state <= ST_RUN;
                        r_d2clk <= 1'b1;
                    end
                end
`ifdef TRI_LAT_SEQ_SCAN_EN
                ST_SCAN: begin
                    // scan_done is raised together with the last active cycle.
                    if (r_cnt == CW'(SCAN_LEN - 1)) begin
                        r_state       <= ST_RUN;
                        r_cnt         <= '0;
                        r_scan_active <= 1'b0;
                        r_scan_done   <= 1'b0;
                    end else begin
                        r_cnt       <= r_cnt + 1'b1;
                        r_scan_done <= (r_cnt == CW'(SCAN_LEN - 2));
                    end
                end
`endif
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign lat_d      = r_lat_d;
    assign lat_d1clk  = r_d1clk;
    assign lat_d2clk  = r_d2clk;
    assign lat_sreset = r_sreset;

endmodule

// File: tb/tb_tri_lat_seq.sv
module tb_tri_lat_seq;

    localparam int NREQ       = 4;
    localparam int WIDTH      = 8;
    localparam int RST_CYCLES = 4;
    localparam int SCAN_LEN   = 16;

    typedef struct packed {
        logic [NREQ-1:0]  g;
        logic [WIDTH-1:0] d;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  thold_req;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  scan_req;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      lat_d;
    logic                  lat_d1clk;
    logic                  lat_d2clk;
    logic                  lat_sreset;
    logic                  scan_active;
    logic                  scan_done;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb_q[$];

    tri_lat_seq #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .RST_CYCLES(RST_CYCLES),
        .SCAN_LEN  (SCAN_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .thold_req  (thold_req),
        .req        (req),
        .req_data   (req_data),
        .scan_req   (scan_req),
        .gnt        (gnt),
        .lat_d      (lat_d),
        .lat_d1clk  (lat_d1clk),
        .lat_d2clk  (lat_d2clk),
        .lat_sreset (lat_sreset),
        .scan_active(scan_active),
        .scan_done  (scan_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = base + 8'(i);
    endtask

    task automatic push(input logic [NREQ-1:0] g, input logic [WIDTH-1:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        sb_q.push_back(e);
    endtask

    task automatic chk_reset_vals();
        chk("rst_gnt",         32'(gnt),         32'd0);
        chk("rst_lat_d",       32'(lat_d),       32'd0);
        chk("rst_d1clk",       32'(lat_d1clk),   32'd0);
        chk("rst_d2clk",       32'(lat_d2clk),   32'd0);
        chk("rst_sreset",      32'(lat_sreset),  32'd1);
        chk("rst_scan_active", 32'(scan_active), 32'd0);
        chk("rst_scan_done",   32'(scan_done),   32'd0);
    endtask

    // Called just after rst falls; returns on the negedge of the first RUN cycle.
    task automatic chk_init_seq();
        for (int i = 0; i < RST_CYCLES; i++) begin
            @(negedge clk);
            chk("init_sreset", 32'(lat_sreset), 32'd1);
            chk("init_d2clk",  32'(lat_d2clk),  32'd0);
            chk("init_done",   32'(scan_done),  32'd0);
        end
        @(negedge clk);
        chk("run_sreset", 32'(lat_sreset), 32'd0);
        chk("run_d2clk",  32'(lat_d2clk),  32'd1);
    endtask

    // Scoreboard monitor: every presented grant is matched against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && gnt !== '0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_gnt", 32'(gnt), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_gnt",   32'(gnt),       32'(e.g));
                chk("sb_lat_d", 32'(lat_d),     32'(e.d));
                chk("sb_d1clk", 32'(lat_d1clk), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        thold_req = 1'b0;
        req       = '0;
        req_data  = '0;
        scan_req  = 1'b0;

        // 1. reset and init sequence
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rst = 1'b0;
        chk_init_seq();

        // 2. round robin with all requesters active
        set_data(8'hA0);
        req = 4'hF;
        push(4'b0001, 8'hA0);
        push(4'b0010, 8'hA1);
        push(4'b0100, 8'hA2);
        push(4'b1000, 8'hA3);
        push(4'b0001, 8'hA0);
        repeat (5) @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("idle_gnt",   32'(gnt),       32'd0);
        chk("idle_d1clk", 32'(lat_d1clk), 32'd0);
        chk("idle_lat_d", 32'(lat_d),     32'hA0);

        // 3. hold for 5 cycles with req[2] pending (rr_ptr = 1)
        thold_req = 1'b1;
        req       = 4'b0100;
        push(4'b0100, 8'hA2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_d2clk", 32'(lat_d2clk), 32'd0);
            chk("hold_gnt",   32'(gnt),       32'd0);
            chk("hold_d1clk", 32'(lat_d1clk), 32'd0);
        end
        thold_req = 1'b0;
        @(negedge clk);
        chk("unhold_d2clk", 32'(lat_d2clk), 32'd1);
        chk("unhold_gnt",   32'(gnt),       32'd0);
        @(negedge clk);
        chk("post_hold_gnt", 32'(gnt), 32'b0100);
        req = '0;

        // partial request patterns (rr_ptr = 3), then wrap to requester 3
        set_data(8'hB0);
        req = 4'b0011;
        push(4'b0001, 8'hB0);
        push(4'b0010, 8'hB1);
        push(4'b0001, 8'hB0);
        repeat (3) @(negedge clk);
        req = 4'b1000;
        push(4'b1000, 8'hB3);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("idle2_gnt",   32'(gnt),   32'd0);
        chk("idle2_lat_d", 32'(lat_d), 32'hB3);

        // 4. scan window with a requester waiting (rr_ptr = 0)
        scan_req = 1'b1;
        req      = 4'b0010;
        push(4'b0010, 8'hB1);
`ifdef TRI_LAT_SEQ_SCAN_EN
        for (int i = 0; i < SCAN_LEN; i++) begin
            @(negedge clk);
            scan_req = 1'b0;
            chk("scan_win", 32'({scan_active, scan_done, gnt, lat_d1clk}),
                32'({1'b1, (i == SCAN_LEN - 1), 4'b0000, 1'b0}));
        end
        @(negedge clk);
        chk("scan_end", 32'({scan_active, scan_done, gnt}), 32'd0);
        @(negedge clk);
        chk("post_scan_gnt", 32'(gnt), 32'b0010);
        req = '0;
`else
        @(negedge clk);
        scan_req = 1'b0;
        chk("noscan_gnt",    32'(gnt),         32'b0010);
        chk("noscan_active", 32'(scan_active), 32'd0);
        req = '0;
        @(negedge clk);
        chk("noscan_done", 32'(scan_done), 32'd0);
`endif

        // 5. simultaneous hold and scan request for 2 cycles
        thold_req = 1'b1;
        scan_req  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("hs_d2clk",  32'(lat_d2clk),   32'd0);
            chk("hs_active", 32'(scan_active), 32'd0);
        end
        thold_req = 1'b0;
        scan_req  = 1'b0;
        @(negedge clk);
        chk("hs_release_d2clk",  32'(lat_d2clk),   32'd1);
        chk("hs_release_active", 32'(scan_active), 32'd0);
`ifdef TRI_LAT_SEQ_SCAN_EN
        for (int i = 0; i < SCAN_LEN; i++) begin
            @(negedge clk);
            chk("hs_scan", 32'({scan_active, scan_done, gnt, lat_d2clk}),
                32'({1'b1, (i == SCAN_LEN - 1), 4'b0000, 1'b1}));
        end
`endif
        @(negedge clk);
        chk("hs_end", 32'({scan_active, scan_done}), 32'd0);

        // 6. reset asserted mid-scan at count 7
        scan_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            scan_req = 1'b0;
            chk("pre_rst_done", 32'(scan_done), 32'd0);
`ifdef TRI_LAT_SEQ_SCAN_EN
            chk("pre_rst_active", 32'(scan_active), 32'd1);
`endif
        end
        rst = 1'b1;
        #1;
        chk_reset_vals();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_init_seq();

        // rr_ptr must be back at 0 after reset
        set_data(8'hC0);
        req = 4'hF;
        push(4'b0001, 8'hC0);
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
